// File: rtl/seq_detect_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// seq_detect_arbiter_pkg
// Shared definitions for the round-robin byte arbiter and its 1011 detector:
//   - arb_state_t : top-level FSM encoding (IDLE, LOAD, SHIFT, REPORT)
//   - det_state_t : overlapping 1011 Mealy detector encoding
//   - BYTE_W, CNT_W, ID_W, BIT_CNT_W : datapath widths
// -----------------------------------------------------------------------------
package seq_detect_arbiter_pkg;

   localparam int BYTE_W    = 8;  // serialised byte width
   localparam int CNT_W     = 2;  // match count width (0..2 per byte)
   localparam int ID_W      = 2;  // requester index width (up to 4 requesters)
   localparam int BIT_CNT_W = 3;  // bit counter 7 down to 0

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      SHIFT  = 2'd2,
      REPORT = 2'd3
   } arb_state_t;

   // Detector states are named after the longest prefix of 1011 seen so far.
   typedef enum logic [1:0] {
      D_NONE = 2'd0,
      D_1    = 2'd1,
      D_10   = 2'd2,
      D_101  = 2'd3
   } det_state_t;

endpackage

// File: rtl/seq_detect_core.sv
// -----------------------------------------------------------------------------
// seq_detect_core
// Overlapping 1011 Mealy detector, one bit per valid cycle.
// Ports:
//   clk      : clock, rising edge
//   reset    : asynchronous active-high reset
//   i_clear  : synchronous clear of detector history (wins over i_valid)
//   i_valid  : i_bit is a new serial bit this cycle
//   i_bit    : serial data bit
//   o_match  : one-cycle pulse, combinational, when i_bit completes 1011
// -----------------------------------------------------------------------------
module seq_detect_core
   import seq_detect_arbiter_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic i_clear,
   input  logic i_valid,
   input  logic i_bit,
   output logic o_match
);

   det_state_t r_state;
   det_state_t w_next;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= D_NONE;
      end else if (i_clear) begin
         r_state <= D_NONE;
      end else if (i_valid) begin
         r_state <= w_next;
      end
   end

   // NOTE: every always_comb output gets a default first, so no path through
   // the case leaves it unassigned and no latch is inferred.
   always_comb begin
      w_next = r_state;
      case (r_state)
         D_NONE: w_next = i_bit ? D_1   : D_NONE;
         D_1:    w_next = i_bit ? D_1   : D_10;
         D_10:   w_next = i_bit ? D_101 : D_NONE;
         // After a full match the trailing 1 is reused as the start of the
         // next pattern; 1010 keeps the trailing 10.
         D_101:  w_next = i_bit ? D_1   : D_10;
         default: w_next = D_NONE;
      endcase
   end

   assign o_match = i_valid && (r_state == D_101) && i_bit;

endmodule

// File: rtl/seq_detect_arbiter.sv
// -----------------------------------------------------------------------------
// seq_detect_arbiter
// Round-robin arbiter over NUM_REQ byte requesters. The granted byte is shifted
// MSB first through a 1011 detector and the number of overlapping matches is
// reported with the requester index.
// Ports:
//   clk       : clock, rising edge
//   reset     : asynchronous active-high reset
//   req       : per-requester request level, held until ack
//   req_data  : byte i at [8i+7:8i], stable while req[i] is high
//   ack       : one-hot pulse in the cycle after the grant (byte captured)
//   busy      : high in every state except IDLE
//   done      : one-cycle pulse, result valid
//   done_id   : requester index of the reported result
//   match_cnt : number of 1011 occurrences in the byte (0..2)
//   match_any : match_cnt != 0
// done_id / match_cnt / match_any hold until the next report.
// -----------------------------------------------------------------------------
module seq_detect_arbiter
   import seq_detect_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*BYTE_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        ack,
   output logic                      busy,
   output logic                      done,
   output logic [ID_W-1:0]           done_id,
   output logic [CNT_W-1:0]          match_cnt,
   output logic                      match_any
);

   arb_state_t           r_state;
   arb_state_t           w_next_state;
   logic [ID_W-1:0]      r_last_grant;
   logic [ID_W-1:0]      r_grant;
   logic [BYTE_W-1:0]    r_shift;
   logic [BIT_CNT_W-1:0] r_bit_cnt;
   logic [CNT_W-1:0]     r_cnt;
   logic [ID_W-1:0]      r_done_id;
   logic [CNT_W-1:0]     r_match_cnt;
   logic                 r_match_any;

   logic                 w_any_req;
   logic [ID_W-1:0]      w_grant_idx;
   logic [2:0]           w_dist;
   logic [2:0]           w_best_dist;
   logic [BYTE_W-1:0]    w_sel_byte;
   logic                 w_match;
   logic [CNT_W-1:0]     w_cnt_next;

   // ---------------------------------------------------------------------------
   // Round-robin pick: each requester's distance from last_grant+1 (mod N);
   // the closest active requester wins.
   // ---------------------------------------------------------------------------
   always_comb begin
      w_any_req   = 1'b0;
      w_grant_idx = '0;
      w_dist      = '0;
      w_best_dist = 3'd7;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_dist = 3'((i + NUM_REQ - 1 - int'(r_last_grant)) % NUM_REQ);
         if (req[i] && (w_dist < w_best_dist)) begin
            w_best_dist = w_dist;
            w_grant_idx = ID_W'(i);
            w_any_req   = 1'b1;
         end
      end
   end

   always_comb begin
      w_sel_byte = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_grant_idx == ID_W'(i)) begin
            w_sel_byte = req_data[i*BYTE_W +: BYTE_W];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      busy         = 1'b1;
      done         = 1'b0;
      ack          = '0;
      case (r_state)
         IDLE: begin
            busy = 1'b0;
            if (w_any_req) begin
               w_next_state = LOAD;
            end
         end
         LOAD: begin
            for (int i = 0; i < NUM_REQ; i++) begin
               ack[i] = (r_grant == ID_W'(i));
            end
            w_next_state = SHIFT;
         end
         SHIFT: begin
            if (r_bit_cnt == '0) begin
               w_next_state = REPORT;
            end
         end
         REPORT: begin
            done         = 1'b1;
            w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath: grant capture, shift register, match counter, result registers
   // ---------------------------------------------------------------------------
   // The last bit's match is combinational, so it is folded in here to make the
   // result registers correct in the REPORT cycle.
   assign w_cnt_next = r_cnt + CNT_W'(w_match);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_last_grant <= ID_W'(NUM_REQ - 1);
         r_grant      <= '0;
         r_shift      <= '0;
         r_bit_cnt    <= '0;
         r_cnt        <= '0;
         r_done_id    <= '0;
         r_match_cnt  <= '0;
         r_match_any  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any_req) begin
                  r_grant      <= w_grant_idx;
                  r_last_grant <= w_grant_idx;
                  r_shift      <= w_sel_byte;
               end
            end
            LOAD: begin
               r_bit_cnt <= BIT_CNT_W'(BYTE_W - 1);
               r_cnt     <= '0;
            end
            SHIFT: begin
               r_shift <= {r_shift[BYTE_W-2:0], 1'b0};
               r_cnt   <= w_cnt_next;
               if (r_bit_cnt == '0) begin
                  r_done_id   <= r_grant;
                  r_match_cnt <= w_cnt_next;
                  r_match_any <= (w_cnt_next != '0);
               end else begin
                  r_bit_cnt <= r_bit_cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   seq_detect_core u_core (
      .clk     (clk),
      .reset   (reset),
      .i_clear (r_state == LOAD),
      .i_valid (r_state == SHIFT),
      .i_bit   (r_shift[BYTE_W-1]),
      .o_match (w_match)
   );

   assign done_id   = r_done_id;
   assign match_cnt = r_match_cnt;
   assign match_any = r_match_any;

endmodule

// File: tb/tb_seq_detect_arbiter.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_arbiter
// Directed stimulus; expected results go into a scoreboard queue and a
// negedge monitor pops and compares them whenever done pulses.
// -----------------------------------------------------------------------------
module tb_seq_detect_arbiter;

   typedef struct {
      logic [1:0] id;
      logic [1:0] cnt;
      logic       any;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  ack;
   logic        busy;
   logic        done;
   logic [1:0]  done_id;
   logic [1:0]  match_cnt;
   logic        match_any;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   last_ack_cyc = -100;
   exp_t q[$];

   always #5 clk = ~clk;

   seq_detect_arbiter #(.NUM_REQ(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .req_data  (req_data),
      .ack       (ack),
      .busy      (busy),
      .done      (done),
      .done_id   (done_id),
      .match_cnt (match_cnt),
      .match_any (match_any)
   );

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int id, input int cnt, input logic any);
      exp_t e;
      e.id  = 2'(id);
      e.cnt = 2'(cnt);
      e.any = any;
      q.push_back(e);
   endtask

   task automatic set_req(input int id, input logic [7:0] b);
      req_data[id*8 +: 8] = b;
      req[id] = 1'b1;
   endtask

   // Waits (bounded) for an ack pulse; returns 0 on timeout.
   task automatic wait_ack(output logic [3:0] a, output int c);
      a = '0;
      c = -1;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (ack != 4'b0000) begin
            a = ack;
            c = cyc;
            return;
         end
      end
   endtask

   task automatic grant(input string name, input int id, input bit drop, output int c);
      logic [3:0] a;
      wait_ack(a, c);
      check(name, a, 4'b0001 << id);
      if (drop) req[id] = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 300 && q.size() != 0; k++) @(negedge clk);
      check("drain_timeout", q.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   // Scoreboard monitor
   logic [3:0] prev_ack  = '0;
   logic       prev_done = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (prev_ack != 4'b0000) check("ack_pulse", ack, 4'b0000);
      if (prev_done) check("done_pulse", done, 1'b0);
      if (ack != 4'b0000) last_ack_cyc = cyc;
      if (done === 1'b1) begin
         if (q.size() == 0) begin
            check("done_unexpected", done, 1'b0);
         end else begin
            e = q.pop_front();
            check("done_id", done_id, e.id);
            check("match_cnt", match_cnt, e.cnt);
            check("match_any", match_any, e.any);
            check("latency", cyc - last_ack_cyc, 9);
         end
      end
      prev_ack  = ack;
      prev_done = done;
   end

   initial begin
      int   c, c_prev;
      exp_t dropped;
      reset    = 1'b1;
      req      = '0;
      req_data = '0;

      // Reset state
      #2;
      check("rst_ack", ack, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_done_id", done_id, 0);
      check("rst_match_cnt", match_cnt, 0);
      check("rst_match_any", match_any, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // B6 from requester 0: two overlapping matches
      push(0, 2, 1'b1);
      set_req(0, 8'hB6);
      grant("grant_b6", 0, 1, c);
      check("busy_load", busy, 1);

      // Single requests 0B, 5A, FF
      push(1, 1, 1'b1);
      set_req(1, 8'h0B);
      grant("grant_0b", 1, 1, c);
      push(2, 1, 1'b1);
      set_req(2, 8'h5A);
      grant("grant_5a", 2, 1, c);
      push(3, 0, 1'b0);
      set_req(3, 8'hFF);
      grant("grant_ff", 3, 1, c);
      drain();
      check("idle_busy", busy, 0);

      // All four at once: order 0..3, 11 cycles apart
      push(0, 2, 1'b1);
      push(1, 1, 1'b1);
      push(2, 0, 1'b0);
      push(3, 1, 1'b1);
      req_data = {8'h5A, 8'hFF, 8'h0B, 8'hB6};
      req      = 4'b1111;
      c_prev   = 0;
      for (int i = 0; i < 4; i++) begin
         grant("grant_all", i, 1, c);
         if (i > 0) check("grant_spacing", c - c_prev, 11);
         c_prev = c;
      end
      drain();

      // Back-to-back 05 then 80 from requester 2, req held between them
      push(2, 0, 1'b0);
      set_req(2, 8'h05);
      grant("grant_05", 2, 0, c);
      req_data[23:16] = 8'h80;
      push(2, 0, 1'b0);
      grant("grant_80", 2, 1, c);
      drain();

      // Reset mid-SHIFT of requester 1 discards the transaction
      push(1, 1, 1'b1);
      set_req(1, 8'h0B);
      grant("grant_pre_rst", 1, 1, c);
      repeat (3) @(negedge clk);
      check("busy_shift", busy, 1);
      #2;
      reset   = 1'b1;
      dropped = q.pop_back();
      #1;
      check("mid_rst_ack", ack, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_done_id", done_id, 0);
      check("mid_rst_match_cnt", match_cnt, 0);
      check("mid_rst_match_any", match_any, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      push(0, 1, 1'b1);
      push(1, 1, 1'b1);
      req_data[7:0]  = 8'h0B;
      req_data[15:8] = 8'h5A;
      req = 4'b0011;
      grant("post_rst_first", 0, 1, c);
      grant("post_rst_second", 1, 1, c);

      // Round-robin wrap: 3 granted, then 1001 -> 0 before 3
      push(3, 1, 1'b1);
      set_req(3, 8'h5A);
      grant("grant_r3", 3, 1, c);
      push(0, 2, 1'b1);
      push(3, 1, 1'b1);
      req_data[7:0]   = 8'hB6;
      req_data[31:24] = 8'h0B;
      req = 4'b1001;
      grant("wrap_first", 0, 1, c);
      grant("wrap_second", 3, 1, c);
      drain();

      // Result outputs hold after done
      repeat (3) @(negedge clk);
      check("hold_done_id", done_id, 3);
      check("hold_match_cnt", match_cnt, 1);
      check("hold_match_any", match_any, 1);
      check("hold_busy", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
